mips_lsu: RTL and testbench

Parametrised load/store unit for the pipelined MIPS core: owns a byte-addressed, big-endian data memory and serves one outstanding byte/halfword/word access at a time with a configurable access latency. It replaces the single-cycle word-only data-memory access in the MEM stage. It adds sub-word loads and stores with sign or zero extension, alignment and range checking, and a `busy` stall signal that the hazard logic uses to freeze the pipeline.

---
 rtl/mips_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mips_lsu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit with a private byte-addressed, big-endian data memory.
// It serves one byte/halfword/word access at a time and adds LAT wait cycles to each access.
// Loads can sign- or zero-extend. Misaligned, reserved-size and out-of-range accesses are
// flagged with err and do not touch memory.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   req                 access request, accepted only while busy is low
//   we, size, sext      store/load, size (00 B, 01 H, 10 W, 11 reserved), sign-extend
//   addr, wdata         byte address, right-justified store data
//   busy                access in progress
//   rvalid, rdata, err  one-cycle completion pulse with load result and error flag
//   dbg_addr, dbg_byte  combinational debug read port (0 when out of range)
module mips_lsu #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 1048576,
    parameter int unsigned LAT    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_byte
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               rel_q;
    logic               capture_c;
    logic               mem_we_c;
    logic               rvalid_d, err_d;
    logic [31:0]        rdata_d;

    logic               we_q, sext_q, err_q;
    logic [1:0]         size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;

    logic [7:0]         mem [DEPTH];
    logic [IDX_W-1:0]   idx0, idx1, idx2, idx3;
    logic [7:0]         b0, b1, b2, b3;
    logic [31:0]        load_c;

    // Alignment, reserved size and range check for one access
    function automatic logic calc_err(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        logic [2:0] nbytes;
        logic       bad;
        nbytes = 3'd1;
        bad    = 1'b0;
        case (sz)
            2'b00: nbytes = 3'd1;
            2'b01: begin nbytes = 3'd2; bad = a[0]; end
            2'b10: begin nbytes = 3'd4; bad = (a[1:0] != 2'b00); end
            default: begin nbytes = 3'd1; bad = 1'b1; end
        endcase
        if (({1'b0, a} + (ADDR_W+1)'(nbytes)) > DEPTH_LIM) bad = 1'b1;
        return bad;
    endfunction

    assign busy = (state == ACCESS);

    // Byte lanes of the captured access; the byte at addr is the most significant
    assign idx0 = IDX_W'(addr_q);
    assign idx1 = idx0 + IDX_W'(1);
    assign idx2 = idx0 + IDX_W'(2);
    assign idx3 = idx0 + IDX_W'(3);
    assign b0   = mem[idx0];
    assign b1   = mem[idx1];
    assign b2   = mem[idx2];
    assign b3   = mem[idx3];

    // Right-justified load datum with optional sign extension
    always_comb begin
        load_c = {b0, b1, b2, b3};
        case (size_q)
            2'b00:   load_c = sext_q ? {{24{b0[7]}}, b0} : {24'h000000, b0};
            2'b01:   load_c = sext_q ? {{16{b0[7]}}, b0, b1} : {16'h0000, b0, b1};
            default: load_c = {b0, b1, b2, b3};
        endcase
    end

    // Next-state and completion logic
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        capture_c = 1'b0;
        mem_we_c  = 1'b0;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        rdata_d   = 32'h0;
        case (state)
            IDLE: begin
                // rel_q blocks sampling on the first edge after reset release
                if (req && rel_q) begin
                    capture_c = 1'b1;
                    cnt_d     = CNT_W'(LAT);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = err_q;
                    mem_we_c = we_q && !err_q;
                    rdata_d  = (we_q || err_q) ? 32'h0 : load_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request capture and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rel_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            rel_q  <= 1'b1;
            if (capture_c) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sext;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= calc_err(size, addr);
            end
            rvalid <= rvalid_d;
            err    <= err_d;
            rdata  <= rdata_d;
        end
    end

    // Memory array; not cleared by reset
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            case (size_q)
                2'b00: mem[idx0] <= wdata_q[7:0];
                2'b01: begin
                    mem[idx0] <= wdata_q[15:8];
                    mem[idx1] <= wdata_q[7:0];
                end
                default: begin
                    mem[idx0] <= wdata_q[31:24];
                    mem[idx1] <= wdata_q[23:16];
                    mem[idx2] <= wdata_q[15:8];
                    mem[idx3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign dbg_byte = ({1'b0, dbg_addr} < DEPTH_LIM) ? mem[IDX_W'(dbg_addr)] : 8'h00;

endmodule

// File: tb/tb_mips_lsu.sv
// Testbench for mips_lsu: directed vectors on a LAT=2 instance, plus a LAT=0 instance
// that is used for back-to-back traffic.
module tb_mips_lsu;

    localparam int unsigned AW = 20;
    localparam int unsigned D  = 1024;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          sext;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    logic          clock, reset_n;
    // LAT=2 instance
    logic          req, we, sext, busy, rvalid, err;
    logic [1:0]    size;
    logic [AW-1:0] addr, dbg_addr;
    logic [31:0]   wdata, rdata;
    logic [7:0]    dbg_byte;
    // LAT=0 instance
    logic          req0, we0, sext0, busy0, rvalid0, err0;
    logic [1:0]    size0;
    logic [AW-1:0] addr0, dbg_addr0;
    logic [31:0]   wdata0, rdata0;
    logic [7:0]    dbg_byte0;

    int checks = 0;
    int errors = 0;

    mips_lsu #(.ADDR_W(AW), .DEPTH(D), .LAT(2)) u_lat2 (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .rvalid(rvalid), .rdata(rdata), .err(err),
        .dbg_addr(dbg_addr), .dbg_byte(dbg_byte)
    );

    mips_lsu #(.ADDR_W(AW), .DEPTH(D), .LAT(0)) u_lat0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .we(we0), .size(size0), .sext(sext0),
        .addr(addr0), .wdata(wdata0), .busy(busy0), .rvalid(rvalid0), .rdata(rdata0), .err(err0),
        .dbg_addr(dbg_addr0), .dbg_byte(dbg_byte0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [AW-1:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // One access on the LAT=2 instance; lat counts edges from accept to the rvalid cycle
    task automatic run_acc(input vec_t v, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clock);
        req = 1'b1; we = v.we; size = v.size; sext = v.sext; addr = v.addr; wdata = v.wdata;
        @(posedge clock);
        #1 req = 1'b0;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        rd = rdata;
        e  = err;
    endtask

    vec_t        vecs[29];
    vec_t        ops0[4];
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [7:0]  exp_b[4];

    initial begin
        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0; dbg_addr = '0;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; sext0 = 1'b0; addr0 = '0; wdata0 = '0; dbg_addr0 = '0;

        vecs[0]  = mk(1'b0, 2'b10, 1'b0, 20'h010, 32'h0, 32'h11223344, 1'b0); // LW
        vecs[1]  = mk(1'b0, 2'b00, 1'b1, 20'h013, 32'h0, 32'h00000044, 1'b0); // LB
        vecs[2]  = mk(1'b0, 2'b01, 1'b0, 20'h012, 32'h0, 32'h00003344, 1'b0); // LHU
        vecs[3]  = mk(1'b0, 2'b01, 1'b1, 20'h010, 32'h0, 32'h00001122, 1'b0); // LH
        vecs[4]  = mk(1'b1, 2'b10, 1'b0, 20'h020, 32'h00000000, 32'h0, 1'b0); // SW 0
        vecs[5]  = mk(1'b1, 2'b00, 1'b0, 20'h020, 32'h00000080, 32'h0, 1'b0); // SB 0x80
        vecs[6]  = mk(1'b0, 2'b00, 1'b1, 20'h020, 32'h0, 32'hFFFFFF80, 1'b0); // LB
        vecs[7]  = mk(1'b0, 2'b00, 1'b0, 20'h020, 32'h0, 32'h00000080, 1'b0); // LBU
        vecs[8]  = mk(1'b1, 2'b01, 1'b0, 20'h022, 32'h0000BEEF, 32'h0, 1'b0); // SH
        vecs[9]  = mk(1'b0, 2'b01, 1'b1, 20'h022, 32'h0, 32'hFFFFBEEF, 1'b0); // LH
        vecs[10] = mk(1'b0, 2'b10, 1'b0, 20'h020, 32'h0, 32'h8000BEEF, 1'b0); // LW
        vecs[11] = mk(1'b0, 2'b10, 1'b0, 20'h012, 32'h0, 32'h0, 1'b1);        // LW misaligned
        vecs[12] = mk(1'b1, 2'b01, 1'b0, 20'h021, 32'h00001234, 32'h0, 1'b1); // SH misaligned
        vecs[13] = mk(1'b1, 2'b11, 1'b0, 20'h020, 32'hFFFFFFFF, 32'h0, 1'b1); // reserved store
        vecs[14] = mk(1'b0, 2'b11, 1'b1, 20'h020, 32'h0, 32'h0, 1'b1);        // reserved load
        vecs[15] = mk(1'b0, 2'b10, 1'b0, 20'h020, 32'h0, 32'h8000BEEF, 1'b0); // unchanged
        vecs[16] = mk(1'b1, 2'b00, 1'b0, 20'h3FE, 32'h0000005A, 32'h0, 1'b0); // SB D-2
        vecs[17] = mk(1'b1, 2'b10, 1'b0, 20'h3FE, 32'hDEADBEEF, 32'h0, 1'b1); // SW D-2
        vecs[18] = mk(1'b0, 2'b00, 1'b0, 20'h3FE, 32'h0, 32'h0000005A, 1'b0); // unchanged
        vecs[19] = mk(1'b1, 2'b00, 1'b0, 20'h3FF, 32'h0000007E, 32'h0, 1'b0); // SB D-1
        vecs[20] = mk(1'b0, 2'b00, 1'b1, 20'h3FF, 32'h0, 32'h0000007E, 1'b0); // LB D-1
        vecs[21] = mk(1'b0, 2'b01, 1'b0, 20'h3FE, 32'h0, 32'h00005A7E, 1'b0); // LHU D-2
        vecs[22] = mk(1'b0, 2'b01, 1'b0, 20'h3FF, 32'h0, 32'h0, 1'b1);        // LH misaligned
        vecs[23] = mk(1'b1, 2'b10, 1'b0, 20'h3FC, 32'hCAFEBABE, 32'h0, 1'b0); // SW D-4
        vecs[24] = mk(1'b0, 2'b10, 1'b0, 20'h3FC, 32'h0, 32'hCAFEBABE, 1'b0); // LW D-4
        vecs[25] = mk(1'b0, 2'b01, 1'b1, 20'h3FC, 32'h0, 32'hFFFFCAFE, 1'b0); // LH D-4
        vecs[26] = mk(1'b0, 2'b10, 1'b0, 20'h400, 32'h0, 32'h0, 1'b1);        // LW at D
        vecs[27] = mk(1'b0, 2'b00, 1'b0, 20'h400, 32'h0, 32'h0, 1'b1);        // LB at D
        vecs[28] = mk(1'b1, 2'b10, 1'b0, 20'h040, 32'h01020304, 32'h0, 1'b0); // SW 0x40

        ops0[0] = mk(1'b1, 2'b10, 1'b0, 20'h008, 32'hA5A50001, 32'h0, 1'b0);
        ops0[1] = mk(1'b0, 2'b10, 1'b0, 20'h008, 32'h0, 32'hA5A50001, 1'b0);
        ops0[2] = mk(1'b1, 2'b10, 1'b0, 20'h00C, 32'h12345678, 32'h0, 1'b0);
        ops0[3] = mk(1'b0, 2'b10, 1'b0, 20'h00C, 32'h0, 32'h12345678, 1'b0);

        // Reset state
        #12;
        chk("reset busy",   32'(busy),   32'h0);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        chk("reset err",    32'(err),    32'h0);
        chk("reset rdata",  rdata,       32'h0);
        chk("reset busy0",  32'(busy0),  32'h0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);

        // SW 0x11223344 to 0x10 with cycle-accurate busy/rvalid
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 20'h010; wdata = 32'h11223344;
        @(posedge clock);
        #1 req = 1'b0;
        chk("sw busy e0", 32'(busy), 32'h1);
        chk("sw rvalid e0", 32'(rvalid), 32'h0);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("sw busy e%0d", k), 32'(busy), 32'h1);
            chk($sformatf("sw rvalid e%0d", k), 32'(rvalid), 32'h0);
        end
        @(posedge clock);
        #1;
        chk("sw busy e3", 32'(busy), 32'h0);
        chk("sw rvalid e3", 32'(rvalid), 32'h1);
        chk("sw err e3", 32'(err), 32'h0);
        chk("sw rdata e3", rdata, 32'h0);
        @(posedge clock);
        #1;
        chk("sw rvalid e4", 32'(rvalid), 32'h0);
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(32'h10 + 32'(i));
            #1;
            chk($sformatf("dbg 0x%0h", 16 + i), 32'(dbg_byte), 32'(exp_b[i]));
        end
        dbg_addr = 20'hFFFFF;
        #1 chk("dbg out of range", 32'(dbg_byte), 32'h0);

        // Table-driven accesses
        for (int i = 0; i < 29; i++) begin
            run_acc(vecs[i], rd, e, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
        end

        // Request held through busy is accepted at k+2+LAT
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 20'h030; wdata = 32'hCAFEF00D;
        @(posedge clock);
        #1 we = 1'b0; wdata = 32'h0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clock);
            #1 chk($sformatf("hold busy e%0d", k), 32'(busy), 32'h1);
        end
        @(posedge clock);
        #1;
        chk("hold rvalid e3", 32'(rvalid), 32'h1);
        chk("hold busy e3", 32'(busy), 32'h0);
        @(posedge clock);
        #1;
        chk("hold busy e4", 32'(busy), 32'h1);
        chk("hold rvalid e4", 32'(rvalid), 32'h0);
        req = 1'b0;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        chk("hold second latency", 32'(lat), 32'd3);
        chk("hold second rdata", rdata, 32'hCAFEF00D);
        chk("hold second err", 32'(err), 32'h0);

        // Reset mid-ACCESS aborts SW 0xDEADBEEF to 0x40
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 20'h040; wdata = 32'hDEADBEEF;
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort rvalid", 32'(rvalid), 32'h0);
        chk("abort rdata", rdata, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(32'h40 + 32'(i));
            #1 chk($sformatf("abort dbg 0x%0h", 64 + i), 32'(dbg_byte), 32'(exp_b[i]));
        end
        run_acc(mk(1'b0, 2'b10, 1'b0, 20'h040, 32'h0, 32'h0, 1'b0), rd, e, lat);
        chk("abort reload", rd, 32'h01020304);

        // LAT=0 back-to-back: one rvalid every 2 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req0 = 1'b1; we0 = ops0[i].we; size0 = ops0[i].size; sext0 = ops0[i].sext;
            addr0 = ops0[i].addr; wdata0 = ops0[i].wdata;
            @(posedge clock);
            #1;
            chk($sformatf("lat0 op%0d busy", i), 32'(busy0), 32'h1);
            chk($sformatf("lat0 op%0d rvalid low", i), 32'(rvalid0), 32'h0);
            @(posedge clock);
            #1;
            chk($sformatf("lat0 op%0d rvalid", i), 32'(rvalid0), 32'h1);
            chk($sformatf("lat0 op%0d busy low", i), 32'(busy0), 32'h0);
            chk($sformatf("lat0 op%0d rdata", i), rdata0, ops0[i].exp_rdata);
            chk($sformatf("lat0 op%0d err", i), 32'(err0), 32'h0);
        end
        req0 = 1'b0;
        dbg_addr0 = 20'h008;
        #1 chk("lat0 dbg 0x8", 32'(dbg_byte0), 32'h000000A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
